// File: rtl/snake_pkg.sv
// Shared encodings for the snake heading controller: directions, PAJ7620
// gesture bit positions, FSM state codes and small decode helpers.
// Pure declarations, no timing or flow-control behaviour of its own.
package snake_pkg;

  // Heading encoding; opposite directions differ only in bit 0.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Bit positions in the PAJ7620 gesture byte.
  localparam int GEST_UP_BIT    = 0;
  localparam int GEST_DOWN_BIT  = 1;
  localparam int GEST_LEFT_BIT  = 2;
  localparam int GEST_RIGHT_BIT = 3;
  localparam int GEST_FWD_BIT   = 4;

  // "Forward" alone toggles pause.
  localparam logic [7:0] GEST_PAUSE = 8'h10;

  // Gesture front-end FSM states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // A direction gesture has exactly one of bits[3:0] set and nothing above.
  function automatic logic gest_is_dir(input logic [7:0] g);
    logic [3:0] lo;
    lo = g[3:0];
    return (g[7:4] == 4'd0) && (lo != 4'd0) && ((lo & (lo - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful when gest_is_dir() holds.
  function automatic logic [1:0] gest_to_dir(input logic [3:0] g);
    logic [1:0] d;
    d = DIR_UP;
    if (g[GEST_DOWN_BIT])  d = DIR_DOWN;
    if (g[GEST_LEFT_BIT])  d = DIR_LEFT;
    if (g[GEST_RIGHT_BIT]) d = DIR_RIGHT;
    return d;
  endfunction

  function automatic logic dir_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// Two-entry queue of pending headings between gesture decode and move ticks.
// Latency: push visible on head/tail/level one cycle later; push+pop in the same cycle both apply.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
// Ports: clk, rst (sync, active-high), push, pop, din[1:0], head[1:0], tail[1:0], level[1:0] (0..2).
module snake_dir_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] head,
  output logic [1:0] tail,
  output logic [1:0] level
);

  logic [1:0] e0;  // oldest entry
  logic [1:0] e1;  // second entry, valid only when level == 2

  always_ff @(posedge clk) begin
    if (rst) begin
      e0    <= 2'd0;
      e1    <= 2'd0;
      level <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (level == 2'd0) begin
            e0    <= din;
            level <= 2'd1;
          end else if (level == 2'd1) begin
            e1    <= din;
            level <= 2'd2;
          end
        end
        2'b01: begin
          if (level != 2'd0) begin
            e0    <= e1;
            level <= level - 2'd1;
          end
        end
        2'b11: begin
          // Level stays put: the new entry replaces the one leaving.
          if (level == 2'd0) begin
            e0    <= din;
            level <= 2'd1;
          end else if (level == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;
  assign tail = (level == 2'd2) ? e1 : e0;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns PAJ7620 gesture bytes into a snake heading with a 2-deep turn queue and pause toggle.
// Latency: gesture change at N -> push/gest_drop at N+1 -> q_level at N+2; move_tick pop -> dir next cycle.
// Backpressure: none; gestures during hold-off are ignored and a full queue drops the candidate.
// Ports: sys_clk, sys_rst (sync, active-high), po_data[7:0], move_tick -> dir[1:0], dir_changed,
//        pause, q_level[1:0], gest_drop.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int         HOLDOFF_CYC = 5_000_000,
  parameter logic [1:0] INIT_DIR    = 2'd3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] po_data,
  input  logic       move_tick,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic       pause,
  output logic [1:0] q_level,
  output logic       gest_drop
);

  localparam int CNT_W = $clog2(HOLDOFF_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       last_data;
  logic [7:0]       cap;

  logic [1:0] q_head;
  logic [1:0] q_tail;
  logic [1:0] cand;
  logic [1:0] ref_dir;
  logic       accept;
  logic       is_dir;
  logic       is_pause;
  logic       push;
  logic       pop;

  // Gesture front end: one acceptance, then a hold-off window.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_data <= 8'd0;
      cap       <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          last_data <= po_data;
          if ((po_data != 8'd0) && (po_data != last_data)) begin
            cap   <= po_data;
            state <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          cnt   <= CNT_LOAD;
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          // Keep tracking the sensor so a gesture held through hold-off does not retrigger.
          last_data <= po_data;
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Classification of the captured byte during the single ACCEPT cycle.
  always_comb begin
    accept    = (state == ST_ACCEPT);
    is_pause  = (cap == GEST_PAUSE);
    is_dir    = gest_is_dir(cap);
    cand      = gest_to_dir(cap[3:0]);
    // A new turn is judged against the last heading the snake will have taken.
    ref_dir   = (q_level != 2'd0) ? q_tail : dir;
    // Registered level gate: a push into an empty queue is never popped in the same cycle.
    pop       = move_tick && !pause && (q_level != 2'd0);
    push      = 1'b0;
    gest_drop = 1'b0;
    if (accept) begin
      if (is_dir) begin
        if (dir_opposite(cand, ref_dir) || (cand == ref_dir) || pause ||
            ((q_level == 2'd2) && !pop)) begin
          gest_drop = 1'b1;
        end else begin
          push = 1'b1;
        end
      end else if (!is_pause) begin
        gest_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dir         <= INIT_DIR;
      dir_changed <= 1'b0;
      pause       <= 1'b0;
    end else begin
      dir_changed <= pop;
      if (pop) dir <= q_head;
      if (accept && is_pause) pause <= ~pause;
    end
  end

  snake_dir_fifo u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .pop   (pop),
    .din   (cand),
    .head  (q_head),
    .tail  (q_tail),
    .level (q_level)
  );

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl with HOLDOFF_CYC=4: vector table, hand-written
// corner sequences, then random stimulus against a queue-based reference model.
module tb_snake_dir_ctrl;

  localparam int HOLD = 4;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] po_data;
  logic       move_tick;
  logic [1:0] dir;
  logic       dir_changed;
  logic       pause;
  logic [1:0] q_level;
  logic       gest_drop;

  int n_cmp = 0;
  int n_bad = 0;

  snake_dir_ctrl #(.HOLDOFF_CYC(HOLD), .INIT_DIR(2'd3)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .po_data     (po_data),
    .move_tick   (move_tick),
    .dir         (dir),
    .dir_changed (dir_changed),
    .pause       (pause),
    .q_level     (q_level),
    .gest_drop   (gest_drop)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic to_neg();
    @(negedge sys_clk);
  endtask

  task automatic to_pos();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int e_dir, input int e_q, input int e_p,
                         input int e_dc, input int e_drop);
    chk({tag, " dir"},         int'(dir),         e_dir);
    chk({tag, " q_level"},     int'(q_level),     e_q);
    chk({tag, " pause"},       int'(pause),       e_p);
    chk({tag, " dir_changed"}, int'(dir_changed), e_dc);
    chk({tag, " gest_drop"},   int'(gest_drop),   e_drop);
  endtask

  // One idle cycle at 0, present v, optionally tick during ACCEPT, ride out hold-off.
  task automatic gesture(input logic [7:0] v, input logic t, input int e_drop, input string nm);
    po_data = 8'h00; to_neg(); to_pos();
    po_data = v;     to_neg(); to_pos();
    move_tick = t;   to_neg(); chk({nm, " gest_drop"}, int'(gest_drop), e_drop); to_pos();
    move_tick = 1'b0;
    repeat (HOLD + 1) begin to_neg(); to_pos(); end
  endtask

  task automatic tick_chk(input int e_dir, input string nm);
    move_tick = 1'b1; to_neg(); to_pos();
    move_tick = 1'b0; to_neg();
    chk({nm, " dir"}, int'(dir), e_dir);
    chk({nm, " dir_changed"}, int'(dir_changed), 1);
    to_pos();
  endtask

  task automatic expect_q(input int e_q, input string nm);
    to_neg(); chk({nm, " q_level"}, int'(q_level), e_q); to_pos();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] po;
    logic       tick;
    int         n;
    int         e_dir, e_q, e_p, e_dc, e_drop;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [7:0] po, input logic tick, input int n, input int e_dir,
                     input int e_q, input int e_p, input int e_dc, input int e_drop);
    vec_t v;
    v.po = po; v.tick = tick; v.n = n;
    v.e_dir = e_dir; v.e_q = e_q; v.e_p = e_p; v.e_dc = e_dc; v.e_drop = e_drop;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [1:0] m_dir;
  bit         m_pause, m_dc, m_pend;
  int         m_q[$];
  logic [7:0] m_last, m_cap;
  int         m_block;

  task automatic m_reset();
    m_dir = 2'd3; m_pause = 0; m_dc = 0; m_pend = 0;
    m_q.delete(); m_last = 8'h00; m_cap = 8'h00; m_block = 0;
  endtask

  task automatic m_eval(input bit tick, output bit drop, output bit push, output bit pop,
                        output bit tog, output int c);
    int refd;
    int nbits;
    drop = 0; push = 0; tog = 0; c = 0; nbits = 0;
    pop = tick && !m_pause && (m_q.size() > 0);
    if (m_pend) begin
      for (int b = 0; b < 4; b++) if (m_cap[b]) begin nbits++; c = b; end
      if (m_cap == 8'h10) tog = 1;
      else if (m_cap[7:4] == 4'd0 && nbits == 1) begin
        refd = (m_q.size() > 0) ? m_q[$] : int'(m_dir);
        if (((refd ^ c) == 1) || (c == refd) || m_pause || (m_q.size() == 2 && !pop)) drop = 1;
        else push = 1;
      end else drop = 1;
    end
  endtask

  logic [7:0] pool [12] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                           8'h03, 8'h20, 8'h81, 8'h00, 8'h01, 8'h08};

  initial begin
    bit e_drop, e_push, e_pop, e_tog;
    int e_c;

    sys_rst = 1'b1; po_data = 8'h00; move_tick = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    to_neg(); chk_all("reset", 3, 0, 0, 0, 0); to_pos();

    //   po     tick n  dir q p dc drop
    add(8'h00, 1, 3, 3, 0, 0, 0, 0);   // ticks with empty queue do nothing
    add(8'h01, 0, 1, 3, 0, 0, 0, 0);   // trigger
    add(8'h01, 0, 1, 3, 0, 0, 0, 0);   // accept: push up
    add(8'h01, 0, 5, 3, 1, 0, 0, 0);   // hold-off, held byte never retriggers
    add(8'h01, 1, 1, 3, 1, 0, 0, 0);   // tick pops
    add(8'h01, 0, 1, 0, 0, 0, 1, 0);
    add(8'h01, 0, 1, 0, 0, 0, 0, 0);
    add(8'h02, 0, 1, 0, 0, 0, 0, 0);
    add(8'h02, 0, 1, 0, 0, 0, 0, 1);   // down is opposite of up
    add(8'h02, 0, 4, 0, 0, 0, 0, 0);
    add(8'h03, 0, 1, 0, 0, 0, 0, 0);
    add(8'h03, 0, 1, 0, 0, 0, 0, 1);   // two bits set
    add(8'h03, 0, 4, 0, 0, 0, 0, 0);
    add(8'h01, 0, 1, 0, 0, 0, 0, 0);
    add(8'h01, 0, 1, 0, 0, 0, 0, 1);   // same as heading
    add(8'h01, 0, 4, 0, 0, 0, 0, 0);
    add(8'h10, 0, 1, 0, 0, 0, 0, 0);
    add(8'h10, 0, 1, 0, 0, 0, 0, 0);   // pause toggle, no drop
    add(8'h10, 0, 4, 0, 0, 1, 0, 0);
    add(8'h04, 0, 1, 0, 0, 1, 0, 0);
    add(8'h04, 0, 1, 0, 0, 1, 0, 1);   // dropped while paused
    add(8'h04, 1, 4, 0, 0, 1, 0, 0);
    add(8'h10, 0, 1, 0, 0, 1, 0, 0);
    add(8'h10, 0, 1, 0, 0, 1, 0, 0);
    add(8'h10, 0, 4, 0, 0, 0, 0, 0);   // unpaused
    add(8'h08, 0, 1, 0, 0, 0, 0, 0);
    add(8'h08, 0, 1, 0, 0, 0, 0, 0);   // push right
    add(8'h08, 0, 4, 0, 1, 0, 0, 0);
    add(8'h10, 0, 1, 0, 1, 0, 0, 0);
    add(8'h10, 0, 1, 0, 1, 0, 0, 0);
    add(8'h10, 1, 4, 0, 1, 1, 0, 0);   // paused ticks keep the queue
    add(8'h00, 0, 1, 0, 1, 1, 0, 0);
    add(8'h10, 0, 1, 0, 1, 1, 0, 0);
    add(8'h10, 0, 1, 0, 1, 1, 0, 0);
    add(8'h10, 0, 1, 0, 1, 0, 0, 0);
    add(8'h10, 1, 1, 0, 1, 0, 0, 0);
    add(8'h10, 0, 1, 3, 0, 0, 1, 0);
    add(8'h10, 0, 2, 3, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        po_data = tbl[i].po; move_tick = tbl[i].tick;
        to_neg();
        chk_all($sformatf("vec%0d.%0d", i, k), tbl[i].e_dir, tbl[i].e_q, tbl[i].e_p,
                tbl[i].e_dc, tbl[i].e_drop);
        to_pos();
      end
    end
    move_tick = 1'b0;

    // Full queue, then a pop coincident with ACCEPT lets a full queue accept.
    gesture(8'h01, 0, 0, "fill_up");
    gesture(8'h04, 0, 0, "fill_left");
    expect_q(2, "full");
    gesture(8'h01, 0, 1, "full_drop");
    expect_q(2, "full_after_drop");
    tick_chk(0, "pop_up");
    expect_q(1, "after_pop");
    gesture(8'h01, 0, 0, "refill_up");
    expect_q(2, "refull");
    gesture(8'h08, 1, 0, "pushpop");
    to_neg();
    chk("pushpop q_level", int'(q_level), 2);
    chk("pushpop dir", int'(dir), 2);
    to_pos();
    tick_chk(0, "drain_up");
    tick_chk(3, "drain_tail_right");
    expect_q(0, "drained");

    // Pause, dropped turn, then reset in the middle of hold-off.
    gesture(8'h10, 0, 0, "pause_on");
    to_neg(); chk("pause_on pause", int'(pause), 1); to_pos();
    po_data = 8'h00; to_neg(); to_pos();
    po_data = 8'h01; to_neg(); to_pos();
    to_neg(); chk("paused_up gest_drop", int'(gest_drop), 1); to_pos();
    move_tick = 1'b1; to_neg(); chk("paused_tick dir", int'(dir), 3); to_pos();
    move_tick = 1'b0;
    sys_rst = 1'b1; to_neg(); to_pos();
    sys_rst = 1'b0;
    to_neg(); chk_all("mid_hold_reset", 3, 0, 0, 0, 0); to_pos();
    // Byte still held after reset release is accepted once.
    to_neg(); chk("held_after_reset gest_drop", int'(gest_drop), 0); to_pos();
    expect_q(1, "held_after_reset");

    // Random stimulus against the reference model.
    po_data = 8'h00; move_tick = 1'b0; sys_rst = 1'b1;
    to_pos();
    sys_rst = 1'b0;
    m_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 5) == 0) po_data = pool[$urandom_range(0, 11)];
      move_tick = ($urandom_range(0, 3) == 0);
      sys_rst   = ($urandom_range(0, 399) == 0);
      to_neg();
      m_eval(move_tick, e_drop, e_push, e_pop, e_tog, e_c);
      chk_all($sformatf("rnd%0d", cyc), int'(m_dir), m_q.size(), int'(m_pause),
              int'(m_dc), int'(e_drop));
      to_pos();
      if (sys_rst) m_reset();
      else begin
        if (e_pop) m_dir = 2'(m_q.pop_front());
        if (e_push) m_q.push_back(e_c);
        m_dc = e_pop;
        if (e_tog) m_pause = !m_pause;
        if (m_pend) begin
          m_pend  = 0;
          m_block = HOLD;
        end else if (m_block > 0) begin
          m_block--;
          m_last = po_data;
        end else begin
          if (po_data != 8'h00 && po_data != m_last) begin
            m_pend = 1;
            m_cap  = po_data;
          end
          m_last = po_data;
        end
      end
    end
    sys_rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
